// File: rtl/uart_pkg.sv
// Shared definitions for the UART receiver slice.
//   rx_state_t : receiver FSM state encoding
//   DATA_BITS  : default data bits per frame
//   OVERSAMPLE : default baud-clock edges per bit period
//   maj3       : 2-of-3 majority vote used for mid-bit sampling
package uart_pkg;

    localparam int unsigned DATA_BITS  = 8;
    localparam int unsigned OVERSAMPLE = 16;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_IDLE = 3'd4
    } rx_state_t;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Byte output handshake of the UART receiver.
//   o_data  : received byte, valid while o_valid is high
//   o_valid : byte available
//   i_ready : consumer takes the byte when o_valid & i_ready
// master = receiver side, slave = consumer side.
interface uart_rx_if import uart_pkg::*; #(
    parameter int unsigned DataBits = DATA_BITS
);

    logic [DataBits-1:0] o_data;
    logic                o_valid;
    logic                i_ready;

    modport master (output o_data, output o_valid, input  i_ready);
    modport slave  (input  o_data, input  o_valid, output i_ready);

endinterface

// File: rtl/uart_rx_sync.sv
// Input conditioning for the UART receiver.
//   i_clk, i_rst_n : system clock, async active-low reset
//   i_baud_clk     : oversampled baud level, already in the i_clk domain
//   i_rx           : asynchronous serial line (idle high)
//   o_rxs          : i_rx after SyncStages flops (registered)
//   o_tick_c       : one-cycle strobe on each rising edge of i_baud_clk
module uart_rx_sync #(
    parameter int unsigned SyncStages = 2
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_baud_clk,
    input  logic i_rx,
    output logic o_rxs,
    output logic o_tick_c
);

    logic [SyncStages-1:0] rx_sync_q;
    logic [SyncStages:0]   rx_chain;
    logic                  baud_q;

    assign rx_chain = {rx_sync_q, i_rx};

    // Synchroniser chain resets to the idle line level so reset never looks like a start bit.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rx_sync_q <= '1;
            baud_q    <= 1'b0;
        end else begin
            rx_sync_q <= rx_chain[SyncStages-1:0];
            baud_q    <= i_baud_clk;
        end
    end

    assign o_rxs    = rx_sync_q[SyncStages-1];
    assign o_tick_c = i_baud_clk & ~baud_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1-style UART receiver with 3-sample majority vote around mid-bit.
//   i_clk, i_rst_n : system clock, async active-low reset
//   i_baud_clk     : baud level toggling at BaudRate*OverSample
//   i_rx           : asynchronous serial input, idle high
//   rx_if          : byte output handshake (o_data / o_valid / i_ready)
//   o_frame_err    : one-cycle pulse, stop bit sampled low
//   o_overrun      : one-cycle pulse, byte dropped because previous one still pending
//   o_busy         : FSM not idle
module uart_rx import uart_pkg::*; #(
    parameter int unsigned DataBits   = DATA_BITS,
    parameter int unsigned OverSample = OVERSAMPLE,
    parameter int unsigned SyncStages = 2
) (
    input  logic      i_clk,
    input  logic      i_rst_n,
    input  logic      i_baud_clk,
    input  logic      i_rx,
    uart_rx_if.master rx_if,
    output logic      o_frame_err,
    output logic      o_overrun,
    output logic      o_busy
);

    localparam int unsigned CntW = $clog2(OverSample);
    localparam int unsigned BitW = $clog2(DataBits);

    localparam logic [CntW-1:0] CntLast = CntW'(OverSample - 1);
    localparam logic [CntW-1:0] CntMm1  = CntW'(OverSample / 2 - 1);
    localparam logic [CntW-1:0] CntMid  = CntW'(OverSample / 2);
    localparam logic [CntW-1:0] CntMp1  = CntW'(OverSample / 2 + 1);
    localparam logic [BitW-1:0] BitLast = BitW'(DataBits - 1);

    localparam logic [2:0] ST_IDLE  = IDLE;
    localparam logic [2:0] ST_START = START;
    localparam logic [2:0] ST_DATA  = DATA;
    localparam logic [2:0] ST_STOP  = STOP;
    localparam logic [2:0] ST_WAIT  = WAIT_IDLE;

    logic                rxs;
    logic                tick_c;
    logic                maj_c;

    logic [2:0]          state_q,  state_d;
    logic [CntW-1:0]     cnt_q,    cnt_d;
    logic [BitW-1:0]     bitidx_q, bitidx_d;
    logic                s0_q,     s0_d;
    logic                s1_q,     s1_d;
    logic [DataBits-1:0] shift_q,  shift_d;
    logic [DataBits-1:0] data_q,   data_d;
    logic                valid_q,  valid_d;
    logic                fe_q,     fe_d;
    logic                ov_q,     ov_d;
    logic                busy_q;

    uart_rx_sync #(.SyncStages(SyncStages)) u_sync (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_baud_clk (i_baud_clk),
        .i_rx       (i_rx),
        .o_rxs      (rxs),
        .o_tick_c   (tick_c)
    );

    // State and datapath registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            bitidx_q <= '0;
            s0_q     <= 1'b0;
            s1_q     <= 1'b0;
            shift_q  <= '0;
            data_q   <= '0;
            valid_q  <= 1'b0;
            fe_q     <= 1'b0;
            ov_q     <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            bitidx_q <= bitidx_d;
            s0_q     <= s0_d;
            s1_q     <= s1_d;
            shift_q  <= shift_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
            fe_q     <= fe_d;
            ov_q     <= ov_d;
            busy_q   <= (state_d != ST_IDLE);
        end
    end

    // Next-state: frame recovery on baud ticks, output handshake every cycle.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        bitidx_d = bitidx_q;
        s0_d     = s0_q;
        s1_d     = s1_q;
        shift_d  = shift_q;
        data_d   = data_q;
        valid_d  = valid_q;
        fe_d     = 1'b0;
        ov_d     = 1'b0;
        // Third vote is the live sample at cnt = M+1.
        maj_c    = maj3(s0_q, s1_q, rxs);

        if (valid_q && rx_if.i_ready) begin
            valid_d = 1'b0;
        end

        if (tick_c) begin
            if (state_q == ST_START || state_q == ST_DATA || state_q == ST_STOP) begin
                cnt_d = (cnt_q == CntLast) ? '0 : cnt_q + CntW'(1);
                if (cnt_q == CntMm1) s0_d = rxs;
                if (cnt_q == CntMid) s1_d = rxs;
            end

            case (state_q)
                ST_IDLE: begin
                    if (!rxs) begin
                        cnt_d   = '0;
                        state_d = ST_START;
                    end
                end
                ST_START: begin
                    if (cnt_q == CntMp1 && maj_c) begin
                        state_d = ST_IDLE;
                    end else if (cnt_q == CntLast) begin
                        bitidx_d = '0;
                        state_d  = ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (cnt_q == CntMp1) begin
                        shift_d = {maj_c, shift_q[DataBits-1:1]};
                    end
                    if (cnt_q == CntLast) begin
                        if (bitidx_q == BitLast) state_d = ST_STOP;
                        else                     bitidx_d = bitidx_q + BitW'(1);
                    end
                end
                ST_STOP: begin
                    // Leave half a bit early so the next start edge is not missed.
                    if (cnt_q == CntMp1) begin
                        if (maj_c) begin
                            state_d = ST_IDLE;
                            if (valid_q && !rx_if.i_ready) begin
                                ov_d = 1'b1;
                            end else begin
                                data_d  = shift_q;
                                valid_d = 1'b1;
                            end
                        end else begin
                            fe_d    = 1'b1;
                            state_d = ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    // A held-low line must return high before another frame is armed.
                    if (rxs) state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    assign rx_if.o_data  = data_q;
    assign rx_if.o_valid = valid_q;
    assign o_frame_err   = fe_q;
    assign o_overrun     = ov_q;
    assign o_busy        = busy_q;

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- 8N1-style UART receiver that consumes the oversampled baud clock from the baud generator and the asynchronous serial line.
- Recovers each frame using majority-vote mid-bit sampling.
- Presents each received byte on a valid/ready output interface towards the downstream FIFO or consumer.
- Flags framing errors and overruns as single-cycle pulses.

Parameters:
- DataBits, 8, number of data bits per frame, LSB first, 5..9 legal.
- OverSample, 16, baud-clock rising edges per bit period; must match the baud generator; even, >= 8.
- SyncStages, 2, flip-flop stages synchronising i_rx into the i_clk domain.

Ports:
- i_clk  in  1  system clock
- i_rst_n  in  1  asynchronous active-low reset
- i_baud_clk  in  1  level from baud generator, toggling at BaudRate*OverSample; synchronous to i_clk
- i_rx  in  1  asynchronous serial input; idle high
- o_data  out  DataBits  received byte, valid while o_valid=1
- o_valid  out  1  byte available
- i_ready  in  1  consumer accepts byte when o_valid & i_ready
- o_frame_err  out  1  one-cycle pulse: stop bit sampled low
- o_overrun  out  1  one-cycle pulse: new byte dropped because previous byte not yet taken
- o_busy  out  1  high whenever FSM is not IDLE

Behaviour:
- Reset (asynchronous, active-low, i_clk domain; polarity and synchronicity are fixed):
  - o_data=0, o_valid=0, o_frame_err=0, o_overrun=0, o_busy=0.
  - Sync chain resets to 1; FSM goes to IDLE; tick counter, bit counter and sample registers clear.
  - Reset mid-frame discards the partial byte; no pulses are emitted.
- Tick:
  - i_baud_clk is registered once; tick = i_baud_clk & ~prev, a one-cycle strobe.
  - No synchroniser on i_baud_clk, because it is already an i_clk register.
  - Every FSM action below happens only on tick cycles.
- Samples:
  - i_rx passes through SyncStages flops; the FSM uses the last stage (rxs).
  - Counter cnt, width clog2(OverSample), runs 0..OverSample-1 and wraps to 0 at the start of each bit.
  - Bit value = majority of rxs captured at cnt = M-1, M and M+1, where M = OverSample/2.
- FSM states:
  - IDLE: on a tick with rxs=0, set cnt=0 and go to START.
  - START: at cnt=M+1, if majority=1 it is a false start and the FSM returns to IDLE. At cnt=OverSample-1, set cnt=0 and go to DATA with bitidx=0.
  - DATA: at cnt=M+1, shift the majority bit into the MSB of the shift register (LSB-first reception). At cnt=OverSample-1, if bitidx=DataBits-1 go to STOP, else increment bitidx.
  - STOP: at cnt=M+1, evaluate the stop bit.
    - Majority=1 with no byte pending: the byte is delivered and the FSM goes to IDLE.
    - Majority=0: o_frame_err pulses, the byte is discarded and the FSM goes to WAIT_IDLE.
    - The FSM leaves STOP half a bit early so the next start edge can be caught.
  - WAIT_IDLE: stay until a tick with rxs=1, then go to IDLE. This stops a held-low line (break) from generating repeated frames.
- Output handshake:
  - Delivery happens on the clock edge of the stop-evaluation tick; o_valid is high from the next cycle.
  - o_data and o_valid hold until the cycle where o_valid & i_ready.
  - Delivery while o_valid=1 and i_ready=0: keep the old o_data, pulse o_overrun, drop the new byte.
  - Delivery in the same cycle as o_valid & i_ready: load the new byte, o_valid stays 1, no overrun.
  - o_frame_err and o_overrun are never high for more than one cycle, and never both in the same cycle.
- Latency: from the start of the stop bit to o_valid = (M+1) ticks + at most 2 i_clk cycles.

Decomposition:
- Shared package uart_pkg holds:
  - enum rx_state_t {IDLE, START, DATA, STOP, WAIT_IDLE}
  - default constants: DATA_BITS=8, OVERSAMPLE=16
  - function maj3
- One sub-module, uart_rx_sync, contains the SyncStages synchroniser for i_rx plus the i_baud_clk edge detector producing tick.
- uart_rx instantiates uart_rx_sync once.

Test Plan:
- Drive 0xA5 at 16 ticks/bit with i_ready=0 -> o_data=0xA5, o_valid=1 held, o_busy=0 afterwards. Raise i_ready for 1 cycle -> o_valid=0.
- Back-to-back frames 0x00 then 0xFF (no idle gap), i_ready=1 -> two accepted bytes 0x00, 0xFF; no o_frame_err, no o_overrun.
- i_rx low for 4 ticks then high -> false start: o_busy pulses then drops; no o_valid, no error pulse.
- Frame 0x3C with stop bit 0, then line held low for 40 ticks, then high -> exactly one o_frame_err pulse, no o_valid, no new frame until after the line returns high.
- Frames 0x11 then 0x22, i_ready=0 -> o_data stays 0x11, one o_overrun pulse at the second stop.
- Single-tick glitch to 0 at cnt=M in a 1 data bit of 0xFF -> 0xFF received. Assert i_rst_n=0 mid-DATA -> all outputs 0 immediately; the next frame 0x5A is received correctly.
